// File: rtl/fc_trigger_sequencer.sv
// Fast-control word generator for the PF link: multi-source L1A arbitration with deadtime and
// token-bucket limiting, per-source statistics, and a BX-scheduled command queue.
module fc_trigger_sequencer #(
  parameter int unsigned NUM_SRC   = 4,
  parameter int unsigned BX_W      = 12,
  parameter int unsigned CNT_W     = 16,
  parameter int unsigned VETO_W    = 12,
  parameter int unsigned TOK_W     = 4,
  parameter int unsigned WIN_W     = 16,
  parameter int unsigned CMD_DEPTH = 4,
  localparam int unsigned SRC_W    = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic                     clk_bx,
  input  logic                     reset,
  input  logic [BX_W-1:0]          cfg_orb_length,
  input  logic [NUM_SRC-1:0]       cfg_src_enable,
  input  logic [VETO_W-1:0]        cfg_veto_len,
  input  logic [TOK_W-1:0]         cfg_burst_max,
  input  logic [WIN_W-1:0]         cfg_burst_window,
  input  logic [3:0]               cfg_calib_len,
  input  logic [NUM_SRC-1:0]       trig_in,
  input  logic                     counter_clear,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [1:0]               cmd_code,
  input  logic [BX_W-1:0]          cmd_bx,
  output logic [7:0]               fc_word,
  output logic [SRC_W-1:0]         l1a_src,
  output logic [BX_W-1:0]          bx_counter,
  output logic [31:0]              orbit_count,
  output logic [NUM_SRC*CNT_W-1:0] accepted_cnt,
  output logic [NUM_SRC*CNT_W-1:0] vetoed_cnt
);

  localparam int unsigned PTR_W  = (CMD_DEPTH > 1) ? $clog2(CMD_DEPTH) : 1;
  localparam int unsigned FILL_W = $clog2(CMD_DEPTH + 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [BX_W-1:0]          bx_q, bx_d;
  logic [31:0]              orbit_q, orbit_d;
  logic [VETO_W-1:0]        dead_q, dead_d;
  logic [TOK_W-1:0]         tok_q, tok_d;
  logic [WIN_W-1:0]         rc_q, rc_d;
  logic [NUM_SRC*CNT_W-1:0] acc_q, acc_d, vet_q, vet_d;
  logic [SRC_W-1:0]         src_q, src_d;
  logic [3:0]               calib_q, calib_d;
  logic                     bcr_q, l1a_q, lrst_q, bclr_q, calib_out_q;
  logic                     ready_q, ready_d;
  logic [PTR_W-1:0]         rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [FILL_W-1:0]        fill_q, fill_d;
  logic [1:0]               fifo_code [CMD_DEPTH];
  logic [BX_W-1:0]          fifo_bx [CMD_DEPTH];

  logic [NUM_SRC-1:0] req, win_oh;
  logic [SRC_W-1:0]   win_idx;
  logic               found, accept, bx_wrap, refill, consume, push, pop;
  logic               acc_inc, vet_inc;
  logic [CNT_W-1:0]   acc_cur, vet_cur;
  logic [1:0]         head_code;
  logic [3:0]         calib_len_eff;

  // Lowest enabled requesting index wins
  always_comb begin
    req     = trig_in & cfg_src_enable;
    win_oh  = '0;
    win_idx = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req[i] && !found) begin
        found      = 1'b1;
        win_idx    = SRC_W'(i);
        win_oh[i]  = 1'b1;
      end
    end
    accept = found && (dead_q == '0) && ((cfg_burst_max == '0) || (tok_q != '0));
    src_d  = accept ? win_idx : src_q;
  end

  always_comb begin
    bx_wrap = (bx_q == cfg_orb_length - BX_W'(1));
    bx_d    = bx_wrap ? '0 : bx_q + BX_W'(1);
    if (counter_clear)  orbit_d = '0;
    else if (bx_wrap)   orbit_d = orbit_q + 32'd1;
    else                orbit_d = orbit_q;

    if (accept)              dead_d = cfg_veto_len;
    else if (dead_q != '0)   dead_d = dead_q - VETO_W'(1);
    else                     dead_d = '0;
  end

  // Token bucket: refill and consume in one cycle cancel; lowering the cap clamps next cycle
  always_comb begin
    refill  = (cfg_burst_window != '0) && (rc_q == cfg_burst_window - WIN_W'(1));
    rc_d    = ((cfg_burst_window == '0) || refill) ? '0 : rc_q + WIN_W'(1);
    consume = accept && (cfg_burst_max != '0);
    tok_d   = tok_q;
    if (refill && !consume && (tok_q < cfg_burst_max)) tok_d = tok_q + TOK_W'(1);
    else if (consume && !refill)                       tok_d = tok_q - TOK_W'(1);
    if (tok_d > cfg_burst_max) tok_d = cfg_burst_max;
  end

  always_comb begin
    acc_d   = acc_q;
    vet_d   = vet_q;
    acc_inc = 1'b0;
    vet_inc = 1'b0;
    acc_cur = '0;
    vet_cur = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      acc_inc = accept && win_oh[i];
      vet_inc = req[i] && !acc_inc;
      acc_cur = acc_q[i*CNT_W +: CNT_W];
      vet_cur = vet_q[i*CNT_W +: CNT_W];
      if (counter_clear) begin
        acc_d[i*CNT_W +: CNT_W] = '0;
        vet_d[i*CNT_W +: CNT_W] = '0;
      end else begin
        if (acc_inc && (acc_cur != CntMax)) acc_d[i*CNT_W +: CNT_W] = acc_cur + CNT_W'(1);
        if (vet_inc && (vet_cur != CntMax)) vet_d[i*CNT_W +: CNT_W] = vet_cur + CNT_W'(1);
      end
    end
  end

  // Command queue: only the head is compared; code 3 is acknowledged but never stored
  always_comb begin
    head_code = fifo_code[rd_ptr_q];
    pop       = (fill_q != '0) && (fifo_bx[rd_ptr_q] == bx_q);
    push      = cmd_valid && ready_q && (cmd_code != 2'd3);
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    fill_d    = fill_q;
    if (pop) rd_ptr_d = (rd_ptr_q == PTR_W'(CMD_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    if (push) wr_ptr_d = (wr_ptr_q == PTR_W'(CMD_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    if (push && !pop)      fill_d = fill_q + FILL_W'(1);
    else if (pop && !push) fill_d = fill_q - FILL_W'(1);
    ready_d = (fill_d != FILL_W'(CMD_DEPTH));

    calib_len_eff = (cfg_calib_len == 4'd0) ? 4'd1 : cfg_calib_len;
    if (pop && (head_code == 2'd2)) calib_d = calib_len_eff;
    else if (calib_q != 4'd0)       calib_d = calib_q - 4'd1;
    else                            calib_d = 4'd0;
  end

  always_ff @(posedge clk_bx) begin
    if (push) begin
      fifo_code[wr_ptr_q] <= cmd_code;
      fifo_bx[wr_ptr_q]   <= cmd_bx;
    end
  end

  always_ff @(posedge clk_bx) begin
    if (reset) begin
      bx_q        <= '0;
      orbit_q     <= '0;
      dead_q      <= '0;
      tok_q       <= cfg_burst_max;
      rc_q        <= '0;
      acc_q       <= '0;
      vet_q       <= '0;
      src_q       <= '0;
      calib_q     <= '0;
      bcr_q       <= 1'b0;
      l1a_q       <= 1'b0;
      lrst_q      <= 1'b0;
      bclr_q      <= 1'b0;
      calib_out_q <= 1'b0;
      ready_q     <= 1'b1;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      fill_q      <= '0;
    end else begin
      bx_q        <= bx_d;
      orbit_q     <= orbit_d;
      dead_q      <= dead_d;
      tok_q       <= tok_d;
      rc_q        <= rc_d;
      acc_q       <= acc_d;
      vet_q       <= vet_d;
      src_q       <= src_d;
      calib_q     <= calib_d;
      bcr_q       <= (bx_q == '0);
      l1a_q       <= accept;
      lrst_q      <= pop && (head_code == 2'd0);
      bclr_q      <= pop && (head_code == 2'd1);
      calib_out_q <= (calib_d != 4'd0);
      ready_q     <= ready_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
    end
  end

  assign fc_word      = {2'b00, calib_out_q, 1'b0, bclr_q, lrst_q, l1a_q, bcr_q};
  assign l1a_src      = src_q;
  assign bx_counter   = bx_q;
  assign orbit_count  = orbit_q;
  assign accepted_cnt = acc_q;
  assign vetoed_cnt   = vet_q;
  assign cmd_ready    = ready_q;

endmodule

// File: tb/tb_fc_trigger_sequencer.sv
// Self-checking bench for fc_trigger_sequencer: directed scenarios plus a randomized run, all
// compared against a cycle-level behavioural model built from integers and a command queue.
module tb_fc_trigger_sequencer;

  localparam int NUM_SRC   = 4;
  localparam int BX_W      = 12;
  localparam int CNT_W     = 4;
  localparam int VETO_W    = 12;
  localparam int TOK_W     = 4;
  localparam int WIN_W     = 16;
  localparam int CMD_DEPTH = 4;
  localparam int SRC_W     = 2;
  localparam int CNT_MAX   = (1 << CNT_W) - 1;

  logic                     clk_bx = 1'b0;
  logic                     reset = 1'b1;
  logic [BX_W-1:0]          cfg_orb_length = 12'd45;
  logic [NUM_SRC-1:0]       cfg_src_enable = 4'hF;
  logic [VETO_W-1:0]        cfg_veto_len = '0;
  logic [TOK_W-1:0]         cfg_burst_max = '0;
  logic [WIN_W-1:0]         cfg_burst_window = '0;
  logic [3:0]               cfg_calib_len = 4'd1;
  logic [NUM_SRC-1:0]       trig_in = '0;
  logic                     counter_clear = 1'b0;
  logic                     cmd_valid = 1'b0;
  logic                     cmd_ready;
  logic [1:0]               cmd_code = 2'd0;
  logic [BX_W-1:0]          cmd_bx = '0;
  logic [7:0]               fc_word;
  logic [SRC_W-1:0]         l1a_src;
  logic [BX_W-1:0]          bx_counter;
  logic [31:0]              orbit_count;
  logic [NUM_SRC*CNT_W-1:0] accepted_cnt;
  logic [NUM_SRC*CNT_W-1:0] vetoed_cnt;

  int checks = 0;
  int failures = 0;

  fc_trigger_sequencer #(
    .NUM_SRC  (NUM_SRC),
    .BX_W     (BX_W),
    .CNT_W    (CNT_W),
    .VETO_W   (VETO_W),
    .TOK_W    (TOK_W),
    .WIN_W    (WIN_W),
    .CMD_DEPTH(CMD_DEPTH)
  ) dut (
    .clk_bx          (clk_bx),
    .reset           (reset),
    .cfg_orb_length  (cfg_orb_length),
    .cfg_src_enable  (cfg_src_enable),
    .cfg_veto_len    (cfg_veto_len),
    .cfg_burst_max   (cfg_burst_max),
    .cfg_burst_window(cfg_burst_window),
    .cfg_calib_len   (cfg_calib_len),
    .trig_in         (trig_in),
    .counter_clear   (counter_clear),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_code        (cmd_code),
    .cmd_bx          (cmd_bx),
    .fc_word         (fc_word),
    .l1a_src         (l1a_src),
    .bx_counter      (bx_counter),
    .orbit_count     (orbit_count),
    .accepted_cnt    (accepted_cnt),
    .vetoed_cnt      (vetoed_cnt)
  );

  always #5 clk_bx = ~clk_bx;

  // ---------------- behavioural model ----------------
  typedef struct {
    int code;
    int bx;
  } cmd_t;

  int          m_bx, m_dead, m_tok, m_rc, m_cal;
  int unsigned m_orbit;
  int          m_acc[NUM_SRC];
  int          m_vet[NUM_SRC];
  cmd_t        m_q[$];
  logic [7:0]  e_fc;
  int          e_src;
  logic        e_ready;

  function automatic void model_step();
    int   orb, winner, issued, len;
    bit   bcr, wrap, accept, refill, consume;
    cmd_t c;
    if (reset) begin
      m_bx = 0; m_orbit = 0; m_dead = 0; m_tok = int'(cfg_burst_max); m_rc = 0; m_cal = 0;
      for (int i = 0; i < NUM_SRC; i++) begin m_acc[i] = 0; m_vet[i] = 0; end
      m_q.delete();
      e_fc = 8'h00; e_src = 0; e_ready = 1'b1;
      return;
    end
    orb  = (cfg_orb_length == 0) ? (1 << BX_W) : int'(cfg_orb_length);
    bcr  = (m_bx == 0);
    wrap = (m_bx == orb - 1);
    winner = -1;
    for (int i = 0; i < NUM_SRC; i++)
      if (trig_in[i] && cfg_src_enable[i] && winner < 0) winner = i;
    accept = (winner >= 0) && (m_dead == 0) && (cfg_burst_max == 0 || m_tok > 0);
    for (int i = 0; i < NUM_SRC; i++) begin
      if (counter_clear) begin
        m_acc[i] = 0; m_vet[i] = 0;
      end else if (trig_in[i] && cfg_src_enable[i]) begin
        if (accept && i == winner) m_acc[i] = (m_acc[i] < CNT_MAX) ? m_acc[i] + 1 : CNT_MAX;
        else                       m_vet[i] = (m_vet[i] < CNT_MAX) ? m_vet[i] + 1 : CNT_MAX;
      end
    end
    if (counter_clear) m_orbit = 0;
    else if (wrap)     m_orbit = m_orbit + 1;
    m_dead = accept ? int'(cfg_veto_len) : ((m_dead > 0) ? m_dead - 1 : 0);
    refill  = (cfg_burst_window != 0) && (m_rc == int'(cfg_burst_window) - 1);
    consume = accept && (cfg_burst_max != 0);
    if (refill && !consume)      m_tok = (m_tok + 1 < int'(cfg_burst_max)) ? m_tok + 1
                                                                          : int'(cfg_burst_max);
    else if (consume && !refill) m_tok = m_tok - 1;
    if (m_tok > int'(cfg_burst_max)) m_tok = int'(cfg_burst_max);
    m_rc = (cfg_burst_window == 0 || refill) ? 0 : (m_rc + 1) % (1 << WIN_W);
    issued = -1;
    if (m_q.size() > 0 && m_q[0].bx == m_bx) begin
      issued = m_q[0].code;
      void'(m_q.pop_front());
    end
    if (cmd_valid && e_ready && cmd_code != 2'd3) begin
      c.code = int'(cmd_code);
      c.bx   = int'(cmd_bx);
      m_q.push_back(c);
    end
    e_ready = (m_q.size() < CMD_DEPTH);
    len = (cfg_calib_len == 0) ? 1 : int'(cfg_calib_len);
    if (issued == 2)    m_cal = len;
    else if (m_cal > 0) m_cal = m_cal - 1;
    m_bx = wrap ? 0 : (m_bx + 1) % (1 << BX_W);
    e_fc = {2'b00, m_cal > 0, 1'b0, issued == 1, issued == 0, accept, bcr};
    if (accept) e_src = winner;
  endfunction

  function automatic logic [NUM_SRC*CNT_W-1:0] pack_acc();
    logic [NUM_SRC*CNT_W-1:0] r;
    for (int i = 0; i < NUM_SRC; i++) r[i*CNT_W +: CNT_W] = CNT_W'(m_acc[i]);
    return r;
  endfunction

  function automatic logic [NUM_SRC*CNT_W-1:0] pack_vet();
    logic [NUM_SRC*CNT_W-1:0] r;
    for (int i = 0; i < NUM_SRC; i++) r[i*CNT_W +: CNT_W] = CNT_W'(m_vet[i]);
    return r;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk_bx);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    cfg_orb_length = 12'd45; cfg_burst_max = 4'd3;
    reset = 1'b1;
    tick();
    tick();
    checks++; if (fc_word !== 8'h00) begin failures++; $display("FAIL reset_fc got=%h want=00", fc_word); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b want=1", cmd_ready); end
    checks++; if (bx_counter !== '0) begin failures++; $display("FAIL reset_bx got=%0d want=0", bx_counter); end
    checks++; if (orbit_count !== 32'd0 || accepted_cnt !== '0 || vetoed_cnt !== '0) begin
      failures++; $display("FAIL reset_counters orbit=%0d acc=%h vet=%h want=0", orbit_count, accepted_cnt, vetoed_cnt);
    end
    reset = 1'b0;
    tick();
    checks++; if (bx_counter !== 12'd1 || fc_word !== 8'h01) begin
      failures++; $display("FAIL reset_first_bcr bx=%0d fc=%h want bx=1 fc=01", bx_counter, fc_word);
    end
  endtask

  task automatic test_orbit();
    int pulses = 0;
    cfg_orb_length = 12'd45;
    do_reset();
    for (int i = 0; i < 135; i++) begin
      tick();
      if (fc_word[0]) pulses++;
      checks++; if (bx_counter !== BX_W'(m_bx) || fc_word[0] !== e_fc[0]) begin
        failures++; $display("FAIL orbit_bx cyc=%0d bx=%0d bcr=%b want bx=%0d bcr=%b", i, bx_counter, fc_word[0], m_bx, e_fc[0]);
      end
    end
    checks++; if (orbit_count !== 32'd3) begin failures++; $display("FAIL orbit_count got=%0d want=3", orbit_count); end
    checks++; if (pulses != 3) begin failures++; $display("FAIL orbit_bcr_pulses got=%0d want=3", pulses); end
  endtask

  task automatic test_deadtime();
    logic [9:0] pat;
    cfg_veto_len = 12'd3; cfg_burst_max = 4'd0; cfg_src_enable = 4'hF;
    do_reset();
    trig_in = 4'b0001;
    for (int i = 0; i < 10; i++) begin
      tick();
      pat[i] = fc_word[1];
    end
    trig_in = '0;
    checks++; if (pat !== 10'b01_0001_0001) begin failures++; $display("FAIL deadtime_pattern got=%b want=0100010001", pat); end
    checks++; if (accepted_cnt[0 +: CNT_W] !== 4'd3 || vetoed_cnt[0 +: CNT_W] !== 4'd7) begin
      failures++; $display("FAIL deadtime_counts acc0=%0d vet0=%0d want 3/7", accepted_cnt[0 +: CNT_W], vetoed_cnt[0 +: CNT_W]);
    end
    cfg_veto_len = '0;
  endtask

  task automatic test_simultaneous();
    cfg_veto_len = '0; cfg_burst_max = '0; cfg_src_enable = 4'hF;
    do_reset();
    trig_in = 4'b0110;
    tick();
    trig_in = '0;
    checks++; if (fc_word[1] !== 1'b1 || l1a_src !== 2'd1) begin
      failures++; $display("FAIL simul_winner l1a=%b src=%0d want 1/1", fc_word[1], l1a_src);
    end
    checks++; if (accepted_cnt[1*CNT_W +: CNT_W] !== 4'd1 || vetoed_cnt[2*CNT_W +: CNT_W] !== 4'd1) begin
      failures++; $display("FAIL simul_counts acc1=%0d vet2=%0d want 1/1", accepted_cnt[1*CNT_W +: CNT_W], vetoed_cnt[2*CNT_W +: CNT_W]);
    end
    cfg_src_enable = 4'b1101;
    trig_in = 4'b0110;
    tick();
    trig_in = '0;
    checks++; if (fc_word[1] !== 1'b1 || l1a_src !== 2'd2) begin
      failures++; $display("FAIL simul_disabled l1a=%b src=%0d want 1/2", fc_word[1], l1a_src);
    end
    checks++; if (vetoed_cnt[1*CNT_W +: CNT_W] !== 4'd0 || accepted_cnt[2*CNT_W +: CNT_W] !== 4'd1) begin
      failures++; $display("FAIL simul_disabled_counts vet1=%0d acc2=%0d want 0/1", vetoed_cnt[1*CNT_W +: CNT_W], accepted_cnt[2*CNT_W +: CNT_W]);
    end
    cfg_src_enable = 4'hF;
  endtask

  task automatic test_burst();
    cfg_burst_max = 4'd2; cfg_burst_window = 16'd100; cfg_veto_len = '0;
    do_reset();
    trig_in = 4'b0001;
    for (int i = 0; i < 5; i++) tick();
    trig_in = '0;
    checks++; if (accepted_cnt[0 +: CNT_W] !== 4'd2 || vetoed_cnt[0 +: CNT_W] !== 4'd3) begin
      failures++; $display("FAIL burst_counts acc0=%0d vet0=%0d want 2/3", accepted_cnt[0 +: CNT_W], vetoed_cnt[0 +: CNT_W]);
    end
    for (int i = 0; i < 96; i++) tick();
    trig_in = 4'b0001;
    tick();
    trig_in = '0;
    checks++; if (fc_word[1] !== 1'b1 || accepted_cnt[0 +: CNT_W] !== 4'd3) begin
      failures++; $display("FAIL burst_refill l1a=%b acc0=%0d want 1/3", fc_word[1], accepted_cnt[0 +: CNT_W]);
    end
    cfg_burst_max = '0; cfg_burst_window = '0;
  endtask

  task automatic test_cmd_queue();
    int pulses = 0;
    logic ready_seen;
    cfg_orb_length = 12'd45; cfg_burst_max = '0;
    do_reset();
    cmd_valid = 1'b1; cmd_code = 2'd0; cmd_bx = 12'd10;
    for (int i = 1; i <= 8; i++) begin
      tick();
      ready_seen = (i < 4);
      checks++; if (cmd_ready !== ready_seen) begin
        failures++; $display("FAIL cmdq_ready push=%0d got=%b want=%b", i, cmd_ready, ready_seen);
      end
    end
    cmd_valid = 1'b0;
    for (int i = 0; i < 190; i++) begin
      tick();
      if (fc_word[2]) begin
        pulses++;
        checks++; if (bx_counter !== 12'd11) begin
          failures++; $display("FAIL cmdq_issue_bx got=%0d want=11", bx_counter);
        end
      end
      checks++; if (fc_word !== e_fc || cmd_ready !== e_ready) begin
        failures++; $display("FAIL cmdq_track fc=%h ready=%b want fc=%h ready=%b", fc_word, cmd_ready, e_fc, e_ready);
      end
    end
    checks++; if (pulses != 4) begin failures++; $display("FAIL cmdq_pulses got=%0d want=4", pulses); end
  endtask

  task automatic test_calib_reset();
    int late = 0;
    cfg_orb_length = 12'd45; cfg_calib_len = 4'd15;
    do_reset();
    cmd_valid = 1'b1;
    cmd_code = 2'd2; cmd_bx = 12'd2;  tick();
    cmd_code = 2'd0; cmd_bx = 12'd30; tick();
    cmd_code = 2'd1; cmd_bx = 12'd40; tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++; if (fc_word[5] !== 1'b1) begin failures++; $display("FAIL calib_active got=%b want=1", fc_word[5]); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if (fc_word !== 8'h00 || cmd_ready !== 1'b1) begin
      failures++; $display("FAIL calib_reset fc=%h ready=%b want 00/1", fc_word, cmd_ready);
    end
    for (int i = 0; i < 100; i++) begin
      tick();
      if (fc_word[5] || fc_word[3] || fc_word[2]) late++;
    end
    checks++; if (late != 0) begin failures++; $display("FAIL calib_after_reset cmd_bits=%0d want=0", late); end
    cfg_calib_len = 4'd1;
  endtask

  task automatic test_clear_and_saturate();
    cfg_veto_len = '0; cfg_burst_max = '0;
    do_reset();
    trig_in = 4'b0011;
    for (int i = 0; i < 20; i++) tick();
    checks++; if (accepted_cnt[0 +: CNT_W] !== 4'hF || vetoed_cnt[1*CNT_W +: CNT_W] !== 4'hF) begin
      failures++; $display("FAIL saturate acc0=%0d vet1=%0d want 15/15", accepted_cnt[0 +: CNT_W], vetoed_cnt[1*CNT_W +: CNT_W]);
    end
    counter_clear = 1'b1;
    tick();
    counter_clear = 1'b0;
    trig_in = '0;
    checks++; if (accepted_cnt !== '0 || vetoed_cnt !== '0 || orbit_count !== 32'd0 || fc_word[1] !== 1'b1) begin
      failures++; $display("FAIL clear_priority acc=%h vet=%h orbit=%0d l1a=%b want 0/0/0/1", accepted_cnt, vetoed_cnt, orbit_count, fc_word[1]);
    end
  endtask

  task automatic test_random();
    int orb;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (cyc == 0 || $urandom_range(0, 299) == 0) begin
        orb = ($urandom_range(0, 7) == 0) ? 1 : $urandom_range(8, 40);
        cfg_orb_length   = BX_W'(orb);
        cfg_veto_len     = VETO_W'($urandom_range(0, 5));
        cfg_burst_max    = TOK_W'($urandom_range(0, 3));
        cfg_burst_window = WIN_W'($urandom_range(0, 12));
        cfg_calib_len    = 4'($urandom_range(0, 4));
        cfg_src_enable   = 4'($urandom);
        reset = 1'b1;
      end else begin
        reset = 1'b0;
      end
      if ($urandom_range(0, 99) == 0) cfg_burst_max = TOK_W'($urandom_range(0, 3));
      trig_in       = 4'($urandom & $urandom);
      counter_clear = ($urandom_range(0, 49) == 0);
      cmd_valid     = ($urandom_range(0, 4) == 0);
      cmd_code      = 2'($urandom);
      cmd_bx        = BX_W'($urandom_range(0, int'(cfg_orb_length) + 1));
      tick();
      checks++; if (fc_word !== e_fc) begin
        failures++; $display("FAIL rand_fc cyc=%0d got=%h want=%h", cyc, fc_word, e_fc);
      end
      checks++; if (bx_counter !== BX_W'(m_bx) || orbit_count !== m_orbit) begin
        failures++; $display("FAIL rand_bx cyc=%0d bx=%0d orbit=%0d want %0d/%0d", cyc, bx_counter, orbit_count, m_bx, m_orbit);
      end
      checks++; if (cmd_ready !== e_ready) begin
        failures++; $display("FAIL rand_ready cyc=%0d got=%b want=%b", cyc, cmd_ready, e_ready);
      end
      checks++; if (accepted_cnt !== pack_acc() || vetoed_cnt !== pack_vet()) begin
        failures++; $display("FAIL rand_stats cyc=%0d acc=%h vet=%h want %h/%h", cyc, accepted_cnt, vetoed_cnt, pack_acc(), pack_vet());
      end
      if (e_fc[1]) begin
        checks++; if (l1a_src !== SRC_W'(e_src)) begin
          failures++; $display("FAIL rand_src cyc=%0d got=%0d want=%0d", cyc, l1a_src, e_src);
        end
      end
    end
    reset = 1'b0; trig_in = '0; cmd_valid = 1'b0; counter_clear = 1'b0;
  endtask

  initial begin
    test_reset();
    test_orbit();
    test_deadtime();
    test_simultaneous();
    test_burst();
    test_cmd_queue();
    test_calib_reset();
    test_clear_and_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
